// File: rtl/sseg_pkg.sv
// ============================================================================
// sseg_pkg : shared constants and types for the seven-segment scan driver
// Rev 1.0
// ============================================================================
`default_nettype none

package sseg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SSEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef logic [3:0] bcd_digit_t;

endpackage

`default_nettype wire

// File: rtl/sseg_scan_driver_hex_to_7_segment.sv
// ============================================================================
// hex_to_7_segment : nibble to active-low segment pattern {g,f,e,d,c,b,a}
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_to_7_segment
  import sseg_pkg::*;
(
  input  bcd_digit_t digit_i,
  output logic [6:0] sseg_o
);

  always_comb begin
    sseg_o = SSEG_BLANK;
    case (digit_i)
      4'h0: sseg_o = 7'b1000000;
      4'h1: sseg_o = 7'b1111001;
      4'h2: sseg_o = 7'b0100100;
      4'h3: sseg_o = 7'b0110000;
      4'h4: sseg_o = 7'b0011001;
      4'h5: sseg_o = 7'b0010010;
      4'h6: sseg_o = 7'b0000010;
      4'h7: sseg_o = 7'b1111000;
      4'h8: sseg_o = 7'b0000000;
      4'h9: sseg_o = 7'b0010000;
      4'hA: sseg_o = 7'b0001000;
      4'hB: sseg_o = 7'b0000011;
      4'hC: sseg_o = 7'b1000110;
      4'hD: sseg_o = 7'b0100001;
      4'hE: sseg_o = 7'b0000110;
      4'hF: sseg_o = 7'b0001110;
      default: sseg_o = SSEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
// ============================================================================
// sseg_scan_driver : 4-digit common-anode multiplexed display driver with
// per-frame value latch. Optional macro LEADING_ZERO_BLANK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] bcd_i,
  input  logic [3:0]  dp_i,
  input  logic        blank_i,
  output logic [3:0]  an_o,
  output logic [6:0]  sseg_o,
  output logic        dp_o
);

  localparam int               CNT_W     = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [1:0]       dig_idx_q, dig_idx_d;
  logic [15:0]      val_q, val_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       sseg_q, sseg_d;
  logic             dp_out_q, dp_out_d;

  logic             tc;
  logic             dead;
  bcd_digit_t       nibble;
  logic [6:0]       dec_seg;
  logic [NUM_DIGITS-1:0] lz_mask;

  assign tc     = (tick_q == TICK_LAST);
  assign dead   = (tick_q == '0);
  assign nibble = val_q[{dig_idx_q, 2'b00} +: 4];

  hex_to_7_segment u_dec (
    .digit_i (nibble),
    .sseg_o  (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;
  // Walk down from the top digit; a nonzero digit or a lit dp stops blanking.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (val_q[4*k +: 4] == 4'h0) && !dp_q[k];
      lz_mask[k] = lz_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    tick_d    = tick_q + 1'b1;
    dig_idx_d = dig_idx_q;
    val_d     = val_q;
    dp_d      = dp_q;
    if (tc) begin
      tick_d    = '0;
      dig_idx_d = dig_idx_q + 2'd1;
      if (dig_idx_q == 2'd3) begin
        val_d = bcd_i;
        dp_d  = dp_i;
      end
    end
  end

  always_comb begin
    an_d     = AN_OFF;
    sseg_d   = SSEG_BLANK;
    dp_out_d = 1'b1;
    if (!dead) begin
      an_d     = ~(4'b0001 << dig_idx_q);
      dp_out_d = ~dp_q[dig_idx_q];
      if (nibble <= 4'd9 && !lz_mask[dig_idx_q]) begin
        sseg_d = dec_seg;
      end
    end
    if (blank_i) begin
      an_d = AN_OFF;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q    <= '0;
      dig_idx_q <= 2'd0;
      val_q     <= 16'h0000;
      dp_q      <= 4'b0000;
      an_q      <= AN_OFF;
      sseg_q    <= SSEG_BLANK;
      dp_out_q  <= 1'b1;
    end else begin
      tick_q    <= tick_d;
      dig_idx_q <= dig_idx_d;
      val_q     <= val_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
      dp_out_q  <= dp_out_d;
    end
  end

  assign an_o   = an_q;
  assign sseg_o = sseg_q;
  assign dp_o   = dp_out_q;

endmodule

`default_nettype wire
